// File: rtl/rv32i_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_mem_pkg
// Description : Shared RV32I memory-access constants, responder FSM states
//               and the funct3 legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [6:0] L_TYPE = 7'b0000011;
    localparam logic [6:0] S_TYPE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_legal_funct3(input logic we, input logic [2:0] funct3);
        if (we) begin
            return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        end
        return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
               (funct3 == LBU) || (funct3 == LHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Selects the addressed byte/half/word lane of a memory word
//               and sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import rv32i_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[{addr_lo, 3'b000} +: 8];
        w_half = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            LB:      rdata = {{24{w_byte[7]}}, w_byte};
            LH:      rdata = {{16{w_half[15]}}, w_half};
            LW:      rdata = word;
            LBU:     rdata = {24'd0, w_byte};
            LHU:     rdata = {16'd0, w_half};
            default: rdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : MEM-stage data-memory responder: valid/ready request, wait
//               states, byte-lane stores, extended loads, held response.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import rv32i_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_WAIT   = 4'(WAIT_CYCLES);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_we, w_we_nxt;
    logic [2:0]  r_funct3, w_funct3_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic        r_req_ready, w_req_ready_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic        r_rsp_err, w_rsp_err_nxt;
    logic        w_mem_wr;

    logic [31:0]         r_mem [DEPTH_WORDS];
    logic [c_ADDR_W-1:0] w_idx;
    logic [31:0]         w_load_data;
    logic [31:0]         w_wdata_rep;
    logic [3:0]          w_be;
    logic                w_misaligned;
    logic                w_req_err;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Legality is judged on the latched request, during the first BUSY cycle.
    assign w_idx        = r_addr[c_ADDR_W+1:2];
    assign w_misaligned = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                          ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_req_err    = !is_legal_funct3(r_we, r_funct3) || w_misaligned ||
                          (r_addr[31:2] >= 30'(DEPTH_WORDS));

    load_extend u_load_extend (
        .word    (r_mem[w_idx]),
        .addr_lo (r_addr[1:0]),
        .funct3  (r_funct3),
        .rdata   (w_load_data)
    );

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            localparam logic [1:0] c_LANE = 2'(gi);
            assign w_be[gi] = (r_funct3[1:0] == 2'b10) ||
                              ((r_funct3[1:0] == 2'b01) && (r_addr[1] == c_LANE[1])) ||
                              ((r_funct3[1:0] == 2'b00) && (r_addr[1:0] == c_LANE));
        end
    endgenerate

    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_wdata_rep = {4{r_wdata[7:0]}};
            2'b01:   w_wdata_rep = {2{r_wdata[15:0]}};
            default: w_wdata_rep = r_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_we        <= w_we_nxt;
            r_funct3    <= w_funct3_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_we_nxt        = r_we;
        w_funct3_nxt    = r_funct3;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_mem_wr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready_nxt = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_we_nxt        = req_we;
                    w_funct3_nxt    = req_funct3;
                    w_addr_nxt      = req_addr;
                    w_wdata_nxt     = req_wdata;
                    w_cnt_nxt       = c_WAIT;
                    w_req_ready_nxt = 1'b0;
                    w_state_nxt     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_req_err) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = 32'd0;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = ST_RESP;
                end else if (r_cnt == 4'd0) begin
                    w_mem_wr        = r_we;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_we ? 32'd0 : w_load_data;
                    w_rsp_err_nxt   = 1'b0;
                    w_state_nxt     = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_rdata_nxt = 32'd0;
                    w_rsp_err_nxt   = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The array is deliberately not reset; only the FSM gates writes.
    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
